// File: rtl/regfile_writeback_pkg.sv
// Shared sizing defaults and register index names for the register-file
// write-back slice.
package regfile_writeback_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 2;
    localparam int NUM_REGS_DEF = 2 ** ADDR_W_DEF;

    // Symbolic register indices as produced by the destination-select logic
    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2,
        R3 = 2'd3
    } reg_idx_e;

endpackage

// File: rtl/wb_bypass_mux.sv
// Read-port select: returns the pending write-back data when it targets the
// same register being read, otherwise the committed array contents.
module wb_bypass_mux #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] rd_data
);

    // A pending entry is newer than the array, so it takes priority on a hit
    always_comb begin
        rd_data = reg_data;
        if (wb_valid && (wb_addr == rd_addr)) begin
            rd_data = wb_data;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write end: a one-entry write-back register in front of a
// small flop array, with two asynchronous read ports that bypass from the
// pending entry so a write is visible to readers one edge after it is
// presented and lands in the array one edge later.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_Register,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] Read_Reg1,
    input  logic [ADDR_W-1:0] Read_Reg2,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    output logic              Pending,
    output logic [ADDR_W-1:0] Pending_Reg
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // Commit the held entry and capture the new request; Flush always empties
    // the entry, and when it coincides with Stall the array is left alone so
    // the dropped entry never lands.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (Flush) begin
            if (!Stall && wb_valid) begin
                regs[wb_addr] <= wb_data;
            end
            wb_valid <= 1'b0;
        end else if (!Stall) begin
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
            end
            wb_valid <= RegWrite;
            wb_addr  <= Write_Register;
            wb_data  <= Write_Data;
        end
    end

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass1 (
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_addr  (Read_Reg1),
        .reg_data (regs[Read_Reg1]),
        .rd_data  (Read_Data1)
    );

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass2 (
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_addr  (Read_Reg2),
        .reg_data (regs[Read_Reg2]),
        .rd_data  (Read_Data2)
    );

    // Pending index reads as zero whenever there is no entry so downstream
    // hazard logic never sees a stale address
    always_comb begin
        Pending     = wb_valid;
        Pending_Reg = wb_valid ? wb_addr : ADDR_W'(R0);
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: one task per scenario, each with its
// own expected values computed by hand.
module tb_regfile_writeback;

    logic       Clk;
    logic       Clear;
    logic       RegWrite;
    logic [1:0] Write_Register;
    logic [7:0] Write_Data;
    logic       Stall;
    logic       Flush;
    logic [1:0] Read_Reg1;
    logic [1:0] Read_Reg2;
    logic [7:0] Read_Data1;
    logic [7:0] Read_Data2;
    logic       Pending;
    logic [1:0] Pending_Reg;

    int passCount  = 0;
    int checkCount = 0;

    regfile_writeback dut (
        .Clk            (Clk),
        .Clear          (Clear),
        .RegWrite       (RegWrite),
        .Write_Register (Write_Register),
        .Write_Data     (Write_Data),
        .Stall          (Stall),
        .Flush          (Flush),
        .Read_Reg1      (Read_Reg1),
        .Read_Reg2      (Read_Reg2),
        .Read_Data1     (Read_Data1),
        .Read_Data2     (Read_Data2),
        .Pending        (Pending),
        .Pending_Reg    (Pending_Reg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        RegWrite       = 1'b0;
        Write_Register = 2'd0;
        Write_Data     = 8'h00;
        Stall          = 1'b0;
        Flush          = 1'b0;
    endtask

    task automatic doReset();
        @(negedge Clk);
        idle();
        Clear = 1'b0;
        #2;
        Clear = 1'b1;
    endtask

    task automatic test_reset();
        Clear = 1'b0;
        idle();
        Read_Reg1 = 2'd1;
        Read_Reg2 = 2'd3;
        #12;
        checkCount++;
        if (Read_Data1 !== 8'h00 || Read_Data2 !== 8'h00) $display("[TB] FAIL reset_data got %h/%h expected 00/00", Read_Data1, Read_Data2);
        else passCount++;
        checkCount++;
        if (Pending !== 1'b0 || Pending_Reg !== 2'd0) $display("[TB] FAIL reset_pending got %b/%0d expected 0/0", Pending, Pending_Reg);
        else passCount++;
        Clear = 1'b1;
    endtask

    task automatic test_write_bypass();
        doReset();
        Read_Reg1 = 2'd2;
        Read_Reg2 = 2'd2;
        RegWrite = 1'b1; Write_Register = 2'd2; Write_Data = 8'hA5;
        #1;
        checkCount++;
        if (Read_Data1 !== 8'h00) $display("[TB] FAIL no_input_bypass got %h expected 00", Read_Data1);
        else passCount++;
        step();
        idle();
        checkCount++;
        if (Read_Data1 !== 8'hA5 || Read_Data2 !== 8'hA5) $display("[TB] FAIL bypass_edge1 got %h/%h expected a5/a5", Read_Data1, Read_Data2);
        else passCount++;
        checkCount++;
        if (Pending !== 1'b1 || Pending_Reg !== 2'd2) $display("[TB] FAIL pending_edge1 got %b/%0d expected 1/2", Pending, Pending_Reg);
        else passCount++;
        step();
        checkCount++;
        if (Read_Data1 !== 8'hA5 || Pending !== 1'b0 || Pending_Reg !== 2'd0) $display("[TB] FAIL commit_edge2 got %h/%b/%0d expected a5/0/0", Read_Data1, Pending, Pending_Reg);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        doReset();
        Read_Reg1 = 2'd1;
        RegWrite = 1'b1; Write_Register = 2'd1; Write_Data = 8'h11;
        step();
        checkCount++;
        if (Read_Data1 !== 8'h11) $display("[TB] FAIL b2b_edge1 got %h expected 11", Read_Data1);
        else passCount++;
        Write_Data = 8'h22;
        step();
        idle();
        checkCount++;
        if (Read_Data1 !== 8'h22 || Pending !== 1'b1) $display("[TB] FAIL b2b_edge2 got %h/%b expected 22/1", Read_Data1, Pending);
        else passCount++;
        step();
        checkCount++;
        if (Read_Data1 !== 8'h22 || Pending !== 1'b0) $display("[TB] FAIL b2b_edge3 got %h/%b expected 22/0", Read_Data1, Pending);
        else passCount++;
        for (int r = 0; r < 4; r++) begin
            if (r != 1) begin
                Read_Reg2 = 2'(r);
                #1;
                checkCount++;
                if (Read_Data2 !== 8'h00) $display("[TB] FAIL b2b_other_r%0d got %h expected 00", r, Read_Data2);
                else passCount++;
            end
        end
    endtask

    task automatic test_stall();
        doReset();
        Read_Reg1 = 2'd3;
        Read_Reg2 = 2'd0;
        RegWrite = 1'b1; Write_Register = 2'd3; Write_Data = 8'h5C;
        step();
        Stall = 1'b1; Write_Register = 2'd0; Write_Data = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            step();
            checkCount++;
            if (Read_Data1 !== 8'h5C || Pending !== 1'b1 || Pending_Reg !== 2'd3) $display("[TB] FAIL stall_hold_c%0d got %h/%b/%0d expected 5c/1/3", c, Read_Data1, Pending, Pending_Reg);
            else passCount++;
            checkCount++;
            if (Read_Data2 !== 8'h00) $display("[TB] FAIL stall_r0_c%0d got %h expected 00", c, Read_Data2);
            else passCount++;
        end
        idle();
        step();
        checkCount++;
        if (Read_Data1 !== 8'h5C || Pending !== 1'b0 || Read_Data2 !== 8'h00) $display("[TB] FAIL stall_release got %h/%b/%h expected 5c/0/00", Read_Data1, Pending, Read_Data2);
        else passCount++;
    endtask

    task automatic test_flush();
        doReset();
        Read_Reg1 = 2'd0;
        Read_Reg2 = 2'd1;
        RegWrite = 1'b1; Write_Register = 2'd0; Write_Data = 8'h77;
        step();
        Flush = 1'b1; Write_Register = 2'd1; Write_Data = 8'h99;
        step();
        idle();
        checkCount++;
        if (Read_Data1 !== 8'h77 || Read_Data2 !== 8'h00 || Pending !== 1'b0) $display("[TB] FAIL flush_commit got %h/%h/%b expected 77/00/0", Read_Data1, Read_Data2, Pending);
        else passCount++;
        step();
        checkCount++;
        if (Read_Data1 !== 8'h77 || Read_Data2 !== 8'h00) $display("[TB] FAIL flush_after got %h/%h expected 77/00", Read_Data1, Read_Data2);
        else passCount++;
    endtask

    task automatic test_flush_stall();
        doReset();
        Read_Reg1 = 2'd2;
        RegWrite = 1'b1; Write_Register = 2'd2; Write_Data = 8'h3C;
        step();
        RegWrite = 1'b0; Flush = 1'b1; Stall = 1'b1;
        step();
        idle();
        checkCount++;
        if (Read_Data1 !== 8'h00 || Pending !== 1'b0) $display("[TB] FAIL flush_stall_drop got %h/%b expected 00/0", Read_Data1, Pending);
        else passCount++;
        step();
        checkCount++;
        if (Read_Data1 !== 8'h00) $display("[TB] FAIL flush_stall_after got %h expected 00", Read_Data1);
        else passCount++;
    endtask

    task automatic test_clear_midrun();
        doReset();
        Read_Reg1 = 2'd1;
        Read_Reg2 = 2'd2;
        RegWrite = 1'b1; Write_Register = 2'd1; Write_Data = 8'hAB;
        step();
        Write_Register = 2'd2; Write_Data = 8'hCD;
        step();
        idle();
        checkCount++;
        if (Read_Data1 !== 8'hAB || Read_Data2 !== 8'hCD || Pending !== 1'b1) $display("[TB] FAIL pre_clear got %h/%h/%b expected ab/cd/1", Read_Data1, Read_Data2, Pending);
        else passCount++;
        @(negedge Clk);
        Clear = 1'b0;
        #1;
        checkCount++;
        if (Read_Data1 !== 8'h00 || Read_Data2 !== 8'h00 || Pending !== 1'b0 || Pending_Reg !== 2'd0) $display("[TB] FAIL async_clear got %h/%h/%b/%0d expected 00/00/0/0", Read_Data1, Read_Data2, Pending, Pending_Reg);
        else passCount++;
        Clear = 1'b1;
        step();
        checkCount++;
        if (Read_Data2 !== 8'h00 || Read_Data1 !== 8'h00) $display("[TB] FAIL clear_dropped got %h/%h expected 00/00", Read_Data1, Read_Data2);
        else passCount++;
    endtask

    // Scenario sequence; every task starts from a fresh reset
    initial begin
        Read_Reg1 = 2'd0;
        Read_Reg2 = 2'd0;
        test_reset();
        test_write_bypass();
        test_back_to_back();
        test_stall();
        test_flush();
        test_flush_stall();
        test_clear_midrun();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
